uart_tx_scheduler: RTL and testbench

Read-side scheduler for the three router output FIFOs. It shares one UART transmitter between the three FIFOs. A channel is granted round-robin, and the grant is held for a whole packet: header, payload, then parity byte. The block drives the FIFO read enables and the UART transmit handshake, and it abandons a packet when the synchronizer issues a soft reset on the granted channel.

---
 rtl/uart_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin read scheduler sharing one UART transmitter between three FIFOs.
// Define SCHED_STATS_EN to add saturating packet sent/abort counters.
module uart_tx_scheduler #(
  parameter int STATS_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vld_out_0,
  input  logic               vld_out_1,
  input  logic               vld_out_2,
  input  logic               soft_reset_0,
  input  logic               soft_reset_1,
  input  logic               soft_reset_2,
  input  logic [7:0]         dout_0,
  input  logic [7:0]         dout_1,
  input  logic [7:0]         dout_2,
  input  logic               tx_busy,
  output logic               read_enb_0,
  output logic               read_enb_1,
  output logic               read_enb_2,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [1:0]         grant,
  output logic               busy
`ifdef SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_sent,
  output logic [STATS_W-1:0] pkt_abort
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_XMIT  = 3'd3;
  localparam logic [2:0] S_SENT  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0] state;
  logic [1:0] last_g;
  logic       first;
  logic [6:0] rem;

  logic       vld_g;
  logic       srst_g;
  logic [7:0] dout_g;
  logic       abort;
  logic [1:0] pick;
  logic [2:0] vld_vec;

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // First valid channel after the last served one, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] v);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    c1 = nxt(last);
    c2 = nxt(c1);
    c3 = nxt(c2);
    if (v[c1])      return c1;
    else if (v[c2]) return c2;
    else            return c3;
  endfunction

`ifdef SCHED_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
  assign pick    = rr_pick(last_g, vld_vec);

  always_comb begin
    vld_g  = 1'b0;
    srst_g = 1'b0;
    dout_g = 8'h00;
    case (grant)
      2'd0: begin vld_g = vld_out_0; srst_g = soft_reset_0; dout_g = dout_0; end
      2'd1: begin vld_g = vld_out_1; srst_g = soft_reset_1; dout_g = dout_1; end
      2'd2: begin vld_g = vld_out_2; srst_g = soft_reset_2; dout_g = dout_2; end
      default: ;
    endcase
  end

  // An abort suppresses every strobe in the cycle it is seen.
  assign abort      = (state != S_IDLE) && srst_g;
  assign read_enb_0 = (state == S_RD) && (grant == 2'd0) && vld_g && !abort;
  assign read_enb_1 = (state == S_RD) && (grant == 2'd1) && vld_g && !abort;
  assign read_enb_2 = (state == S_RD) && (grant == 2'd2) && vld_g && !abort;
  assign tx_start   = (state == S_XMIT) && !tx_busy && !abort;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      grant     <= 2'b11;
      last_g    <= 2'd2;
      first     <= 1'b0;
      rem       <= 7'd0;
      tx_data   <= 8'h00;
`ifdef SCHED_STATS_EN
      pkt_sent  <= '0;
      pkt_abort <= '0;
`endif
    end else if (abort) begin
      state  <= S_IDLE;
      last_g <= grant;
      grant  <= 2'b11;
`ifdef SCHED_STATS_EN
      pkt_abort <= sat_inc(pkt_abort);
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|vld_vec) begin
            grant <= pick;
            first <= 1'b1;
            state <= S_RD;
          end
        end
        S_RD: begin
          if (vld_g) state <= S_CAP;
        end
        S_CAP: begin
          tx_data <= dout_g;
          // rem counts bytes still to read after this one: payload plus parity.
          if (first) begin
            rem   <= {1'b0, dout_g[7:2]} + 7'd1;
            first <= 1'b0;
          end else begin
            rem <= rem - 7'd1;
          end
          state <= S_XMIT;
        end
        S_XMIT: begin
          if (!tx_busy) state <= S_SENT;
        end
        S_SENT: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            if (rem == 7'd0) begin
              last_g <= grant;
              grant  <= 2'b11;
              state  <= S_IDLE;
`ifdef SCHED_STATS_EN
              pkt_sent <= sat_inc(pkt_sent);
`endif
            end else if (vld_g) begin
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with FIFO and UART models.
// Build with SCHED_STATS_EN defined to also check the packet counters.
module tb_uart_tx_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [2:0] vreg = 3'b000;
  logic [2:0] hold;
  logic [2:0] srst;
  logic       force_busy;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] dout_0 = 8'h00, dout_1 = 8'h00, dout_2 = 8'h00;
  logic       tx_busy;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       busy;
`ifdef SCHED_STATS_EN
  logic [15:0] pkt_sent, pkt_abort;
`endif

  assign vld_out_0    = vreg[0] & ~hold[0];
  assign vld_out_1    = vreg[1] & ~hold[1];
  assign vld_out_2    = vreg[2] & ~hold[2];
  assign soft_reset_0 = srst[0];
  assign soft_reset_1 = srst[1];
  assign soft_reset_2 = srst[2];

  uart_tx_scheduler #(.STATS_W(16)) dut (
    .clock(clock), .reset(reset),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .tx_busy(tx_busy),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .busy(busy)
`ifdef SCHED_STATS_EN
    , .pkt_sent(pkt_sent), .pkt_abort(pkt_abort)
`endif
  );

  // FIFO contents: everything ever loaded, consumed through a read pointer.
  logic [7:0] ld0[$], ld1[$], ld2[$];
  int rp[3]    = '{0, 0, 0};
  int rdcnt[3] = '{0, 0, 0};

  always @(posedge clock) begin
    if (read_enb_0) begin dout_0 <= ld0[rp[0]]; rp[0]++; rdcnt[0]++; end
    if (read_enb_1) begin dout_1 <= ld1[rp[1]]; rp[1]++; rdcnt[1]++; end
    if (read_enb_2) begin dout_2 <= ld2[rp[2]]; rp[2]++; rdcnt[2]++; end
    if (srst[0]) rp[0] = ld0.size();
    if (srst[1]) rp[1] = ld1.size();
    if (srst[2]) rp[2] = ld2.size();
    vreg[0] <= (rp[0] < ld0.size());
    vreg[1] <= (rp[1] < ld1.size());
    vreg[2] <= (rp[2] < ld2.size());
  end

  int utime = 4;
  int ucnt  = 0;
  int txcnt = 0;
  assign tx_busy = (ucnt != 0) || force_busy;

  always @(posedge clock) begin
    if (tx_start) begin
      txcnt++;
      ucnt <= utime;
    end else if (ucnt > 0) begin
      ucnt <= ucnt - 1;
    end
  end

  // Reference model state: staged packets per channel and expected {channel, byte} stream.
  logic [7:0] s0[$], s1[$], s2[$];
  logic [9:0] exp_q[$];
  int mdl_last = 2;
  int errors = 0;
  int checks = 0;
  int nr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int st_size(input int ch);
    case (ch)
      0: return s0.size();
      1: return s1.size();
      default: return s2.size();
    endcase
  endfunction

  task automatic st_pop(input int ch, output logic [7:0] b);
    case (ch)
      0: b = s0.pop_front();
      1: b = s1.pop_front();
      default: b = s2.pop_front();
    endcase
  endtask

  task automatic ld_byte(input int ch, input logic [7:0] b);
    case (ch)
      0: ld0.push_back(b);
      1: ld1.push_back(b);
      default: ld2.push_back(b);
    endcase
  endtask

  task automatic add_byte(input int ch, input logic [7:0] b);
    ld_byte(ch, b);
    case (ch)
      0: s0.push_back(b);
      1: s1.push_back(b);
      default: s2.push_back(b);
    endcase
  endtask

  task automatic add_pkt(input int ch, input int len);
    logic [5:0] l6;
    logic [1:0] a;
    l6 = len[5:0];
    a  = 2'($urandom_range(0, 3));
    add_byte(ch, {l6, a});
    for (int i = 0; i < len; i++) add_byte(ch, 8'($urandom));
    add_byte(ch, 8'($urandom));
  endtask

  // Packet-level round robin: whole packets, next non-empty channel after the last one served.
  task automatic commit();
    logic [7:0] b;
    int cc;
    int n;
    while (st_size(0) + st_size(1) + st_size(2) > 0) begin
      cc = -1;
      for (int k = 1; k <= 3; k++)
        if (cc < 0 && st_size((mdl_last + k) % 3) > 0) cc = (mdl_last + k) % 3;
      st_pop(cc, b);
      exp_q.push_back({cc[1:0], b});
      n = int'(b[7:2]) + 1;
      for (int i = 0; i < n; i++) begin
        st_pop(cc, b);
        exp_q.push_back({cc[1:0], b});
      end
      mdl_last = cc;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(name, 32'(k < budget), 1);
  endtask

  task automatic wait_rd(input string name, input int ch, input int target);
    int k;
    k = 0;
    while (rdcnt[ch] < target && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk(name, 32'(rdcnt[ch]), 32'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, {29'd0, read_enb_2, read_enb_1, read_enb_0}, 0);
    chk({tag, "_txs"}, 32'(tx_start), 0);
    chk({tag, "_txd"}, 32'(tx_data), 0);
    chk({tag, "_grant"}, 32'(grant), 3);
    chk({tag, "_busy"}, 32'(busy), 0);
`ifdef SCHED_STATS_EN
    chk({tag, "_sent"}, 32'(pkt_sent), 0);
    chk({tag, "_abort"}, 32'(pkt_abort), 0);
`endif
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    srst  = 3'b111;
    step();
    step();
    reset = 1'b0;
    srst  = 3'b000;
    mdl_last = 2;
    @(negedge clock);
    chk_reset_vals("reset");
  endtask

  initial begin
    int r0, t0, base;
    logic [7:0] par;
    reset = 1'b1;
    hold = 3'b000;
    srst = 3'b000;
    force_busy = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          nr = int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2);
          if (nr != 0) begin
            chk("rd_onehot", 32'(nr <= 1), 1);
            chk("rd_vld", 32'((read_enb_0 & ~vld_out_0) | (read_enb_1 & ~vld_out_1) |
                              (read_enb_2 & ~vld_out_2)), 0);
          end
          if (tx_start) begin
            chk("tx_while_busy", 32'(tx_busy), 0);
            chk("tx_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("tx_byte", {22'd0, grant, tx_data}, {22'd0, exp_q.pop_front()});
          end
        end
      end
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("init");
    do_reset();

    // Single packet on channel 1.
    step();
    utime = 4;
    add_byte(1, 8'h09); add_byte(1, 8'hA5); add_byte(1, 8'h5A); add_byte(1, 8'h3C);
    commit();
    r0 = rdcnt[1]; t0 = txcnt;
    wait_done("t1_done", 3000);
    chk("t1_reads", 32'(rdcnt[1] - r0), 4);
    chk("t1_txs", 32'(txcnt - t0), 4);
    chk("t1_grant", 32'(grant), 3);
    chk("t1_busy", 32'(busy), 0);

    // One empty-payload packet on every channel straight after reset.
    do_reset();
    step();
    for (int c = 0; c < 3; c++) add_pkt(c, 0);
    commit();
    wait_done("t2_done", 3000);
`ifdef SCHED_STATS_EN
    chk("t2_sent", 32'(pkt_sent), 3);
`endif

    // Maximum length packet.
    step();
    utime = 2;
    add_byte(1, 8'hFC);
    for (int i = 0; i < 64; i++) add_byte(1, 8'($urandom));
    commit();
    r0 = rdcnt[1]; t0 = txcnt;
    wait_done("t3_done", 3000);
    chk("t3_reads", 32'(rdcnt[1] - r0), 65);
    chk("t3_txs", 32'(txcnt - t0), 65);

    // FIFO 0 runs dry mid-packet: the scheduler must hold the grant and wait.
    step();
    utime = 3;
    add_pkt(0, 5);
    commit();
    base = rdcnt[0];
    wait_rd("t4_part", 0, base + 3);
    hold[0] = 1'b1;
    repeat (40) @(negedge clock);
    chk("t4_no_read", 32'(rdcnt[0] - base), 3);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_grant", 32'(grant), 0);
    hold[0] = 1'b0;
    wait_done("t4_done", 3000);
    chk("t4_reads", 32'(rdcnt[0] - base), 7);

    // Soft reset on the granted channel while it waits in XMIT.
    do_reset();
    step();
    utime = 4;
    ld_byte(0, 8'h14);
    for (int i = 0; i < 6; i++) ld_byte(0, 8'($urandom));
    par = 8'($urandom);
    ld_byte(1, 8'h01); ld_byte(1, par);
    exp_q.push_back({2'd0, 8'h14});
    exp_q.push_back({2'd1, 8'h01});
    exp_q.push_back({2'd1, par});
    mdl_last = 1;
    base = rdcnt[0];
    wait_rd("t5_part", 0, base + 2);
    force_busy = 1'b1;
    @(negedge clock);
    chk("t5_xmit_hold", 32'(tx_start), 0);
    chk("t5_xmit_busy", 32'(busy), 1);
    srst[0] = 1'b1;
    @(negedge clock);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_grant", 32'(grant), 3);
    srst[0] = 1'b0;
    force_busy = 1'b0;
    wait_done("t5_done", 3000);
    chk("t5_reads0", 32'(rdcnt[0] - base), 2);
`ifdef SCHED_STATS_EN
    chk("t5_abort_cnt", 32'(pkt_abort), 1);
    chk("t5_sent_cnt", 32'(pkt_sent), 1);
`endif

    // Hard reset mid-payload on channel 2.
    step();
    utime = 3;
    ld_byte(2, 8'h22);
    for (int i = 0; i < 9; i++) ld_byte(2, 8'(8'h40 + i));
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd2, 8'h40});
    exp_q.push_back({2'd2, 8'h41});
    base = rdcnt[2];
    wait_rd("t6_part", 2, base + 4);
    reset = 1'b1;
    srst[2] = 1'b1;
    @(negedge clock);
    chk_reset_vals("t6_reset");
    reset = 1'b0;
    srst[2] = 1'b0;
    mdl_last = 2;
    chk("t6_exp_drained", 32'(exp_q.size()), 0);
    step();
    add_pkt(2, 3);
    add_pkt(0, 2);
    commit();
    wait_done("t6_done", 3000);

    // Randomized packet mixes.
    for (int round = 0; round < 20; round++) begin
      step();
      utime = $urandom_range(1, 5);
      for (int c = 0; c < 3; c++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(0, 10));
      end
      commit();
      wait_done("rand_done", 6000);
    end

    repeat (5) @(negedge clock);
    chk("final_idle", 32'(busy), 0);
    chk("final_exp_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
